// File: rtl/mult_div_unit_pkg.sv
// Shared op codes, FSM states and op-class helpers for the multiply/divide unit.
package mult_div_unit_pkg;

   localparam logic [2:0] OpMult  = 3'd0;
   localparam logic [2:0] OpMultu = 3'd1;
   localparam logic [2:0] OpDiv   = 3'd2;
   localparam logic [2:0] OpDivu  = 3'd3;
   localparam logic [2:0] OpMthi  = 3'd4;
   localparam logic [2:0] OpMtlo  = 3'd5;

   typedef enum logic {
      StIdle,
      StBusy
   } state_e;

   function automatic logic is_mult(logic [2:0] op);
      return (op == OpMult) || (op == OpMultu);
   endfunction

   function automatic logic is_div(logic [2:0] op);
      return (op == OpDiv) || (op == OpDivu);
   endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the EX stage (master) and the multiply/divide unit (slave).
interface mult_div_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic             cancel;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             busy;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, cancel, src_a, src_b,
      input  busy, hi, lo
   );

   modport slave (
      input  start, op, cancel, src_a, src_b,
      output busy, hi, lo
   );
endinterface

// File: rtl/mult_div_unit_core.sv
// Combinational signed/unsigned multiply and divide producing the full {hi,lo} result.
// res_wr is low for a divide by zero so the caller leaves HI/LO untouched.
module mult_div_unit_core
   import mult_div_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo,
   output logic             res_wr
);

   logic               is_signed;
   logic [2*WIDTH-1:0] a_ext;
   logic [2*WIDTH-1:0] b_ext;
   logic [2*WIDTH-1:0] prod;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   b_safe;
   logic [WIDTH-1:0]   q_mag;
   logic [WIDTH-1:0]   r_mag;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;
   logic               div_by_zero;

   assign is_signed = (op == OpMult) || (op == OpDiv);

   // Low 2*WIDTH bits of a product of sign-extended operands equal the signed product.
   assign a_ext = is_signed ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
   assign b_ext = is_signed ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
   assign prod  = a_ext * b_ext;

   assign a_neg       = is_signed & src_a[WIDTH-1];
   assign b_neg       = is_signed & src_b[WIDTH-1];
   assign a_mag       = a_neg ? -src_a : src_a;
   assign b_mag       = b_neg ? -src_b : src_b;
   assign div_by_zero = (src_b == '0);
   assign b_safe      = div_by_zero ? WIDTH'(1) : b_mag;
   assign q_mag       = a_mag / b_safe;
   assign r_mag       = a_mag % b_safe;

   // MIN / -1 falls out as quotient MIN, remainder 0 through the magnitude path.
   assign quot = (a_neg ^ b_neg) ? -q_mag : q_mag;
   assign rem  = a_neg ? -r_mag : r_mag;

   always_comb begin
      res_hi = '0;
      res_lo = '0;
      res_wr = 1'b0;
      if (is_mult(op)) begin
         {res_hi, res_lo} = prod;
         res_wr           = 1'b1;
      end else if (is_div(op)) begin
         res_hi = rem;
         res_lo = quot;
         res_wr = ~div_by_zero;
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is computed at issue,
// parked in pending registers and committed once the configured latency has elapsed.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input logic            clk,
   input logic            reset,
   mult_div_unit_if.slave bus
);

   localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles + 1);

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
   logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
   logic             pend_wr_q, pend_wr_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] res_lo;
   logic             res_wr;

   mult_div_unit_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .op    (bus.op),
      .src_a (bus.src_a),
      .src_b (bus.src_b),
      .res_hi(res_hi),
      .res_lo(res_lo),
      .res_wr(res_wr)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_wr_d = pend_wr_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start && !bus.cancel) begin
               if (is_mult(bus.op) || is_div(bus.op)) begin
                  pend_hi_d = res_hi;
                  pend_lo_d = res_lo;
                  pend_wr_d = res_wr;
                  cnt_d     = is_mult(bus.op) ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
                  state_d   = StBusy;
               end else if (bus.op == OpMthi) begin
                  hi_d = bus.src_a;
               end else if (bus.op == OpMtlo) begin
                  lo_d = bus.src_a;
               end
            end
         end
         StBusy: begin
            // Any start seen here is ignored; cancel wins over completion.
            if (bus.cancel) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q == CntW'(1)) begin
               state_d = StIdle;
               cnt_d   = '0;
               if (pend_wr_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_wr_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_wr_q <= pend_wr_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign bus.busy = (state_q == StBusy);
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed tables, hand-written flush/reset/overlap sequences and
// random ops against an arithmetic reference model, on a 32-bit and a 16-bit instance.
module tb_mult_div_unit;

   logic clk;
   logic reset;

   int tests  = 0;
   int failed = 0;

   logic [31:0] m_hi[2];
   logic [31:0] m_lo[2];

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vec_a[9];
   vec_t vec_b[3];

   mult_div_unit_if #(.WIDTH(32)) bus_a ();
   mult_div_unit_if #(.WIDTH(16)) bus_b ();

   mult_div_unit #(
      .WIDTH      (32),
      .MULT_CYCLES(5),
      .DIV_CYCLES (10)
   ) dut_a (
      .clk  (clk),
      .reset(reset),
      .bus  (bus_a)
   );

   mult_div_unit #(
      .WIDTH      (16),
      .MULT_CYCLES(1),
      .DIV_CYCLES (3)
   ) dut_b (
      .clk  (clk),
      .reset(reset),
      .bus  (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic int latency(int sel, logic [2:0] op);
      if (op <= 3'd1) return (sel == 0) ? 5 : 1;
      if (op <= 3'd3) return (sel == 0) ? 10 : 3;
      return 0;
   endfunction

   function automatic logic [31:0] get_busy(int sel);
      return (sel == 0) ? {31'd0, bus_a.busy} : {31'd0, bus_b.busy};
   endfunction

   function automatic logic [31:0] get_hi(int sel);
      return (sel == 0) ? bus_a.hi : {16'd0, bus_b.hi};
   endfunction

   function automatic logic [31:0] get_lo(int sel);
      return (sel == 0) ? bus_a.lo : {16'd0, bus_b.lo};
   endfunction

   task automatic drive(int sel, logic st, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                        logic cn);
      if (sel == 0) begin
         bus_a.start  = st;
         bus_a.op     = op;
         bus_a.src_a  = a;
         bus_a.src_b  = b;
         bus_a.cancel = cn;
      end else begin
         bus_b.start  = st;
         bus_b.op     = op;
         bus_b.src_a  = a[15:0];
         bus_b.src_b  = b[15:0];
         bus_b.cancel = cn;
      end
   endtask

   // Reference model: plain integer arithmetic at 64 bits, masked to the instance width.
   task automatic model_step(int sel, logic [2:0] op, logic [31:0] a, logic [31:0] b);
      int              w;
      longint unsigned mask, ua, ub, p;
      longint          sa, sb;
      w    = (sel == 0) ? 32 : 16;
      mask = (64'd1 << w) - 64'd1;
      ua   = {32'd0, a} & mask;
      ub   = {32'd0, b} & mask;
      sa   = longint'(ua);
      sb   = longint'(ub);
      if (ua[w-1]) sa = sa - (longint'(1) << w);
      if (ub[w-1]) sb = sb - (longint'(1) << w);
      case (op)
         3'd0: begin
            p = sa * sb;
            m_hi[sel] = 32'((p >> w) & mask);
            m_lo[sel] = 32'(p & mask);
         end
         3'd1: begin
            p = ua * ub;
            m_hi[sel] = 32'((p >> w) & mask);
            m_lo[sel] = 32'(p & mask);
         end
         3'd2: if (ub != 0) begin
            m_lo[sel] = 32'(longint'(sa / sb) & mask);
            m_hi[sel] = 32'(longint'(sa % sb) & mask);
         end
         3'd3: if (ub != 0) begin
            m_lo[sel] = 32'((ua / ub) & mask);
            m_hi[sel] = 32'((ua % ub) & mask);
         end
         3'd4: m_hi[sel] = 32'(ua);
         3'd5: m_lo[sel] = 32'(ua);
         default: ;
      endcase
   endtask

   // Issue one op, check busy for its whole latency, then check hi/lo against exp_*.
   task automatic run_op(int sel, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                         logic [31:0] exp_hi, logic [31:0] exp_lo, string name);
      int n;
      n = latency(sel, op);
      @(negedge clk);
      drive(sel, 1'b1, op, a, b, 1'b0);
      #1 check({name, " busy before edge"}, get_busy(sel), 32'd0);
      @(negedge clk);
      drive(sel, 1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s busy c%0d", name, i + 1), get_busy(sel), 32'd1);
         @(negedge clk);
      end
      check({name, " busy done"}, get_busy(sel), 32'd0);
      check({name, " hi"}, get_hi(sel), exp_hi);
      check({name, " lo"}, get_lo(sel), exp_lo);
   endtask

   task automatic random_ops(int sel, int count);
      logic [2:0]  op;
      logic [31:0] a, b;
      int          pick;
      for (int k = 0; k < count; k++) begin
         op   = 3'($urandom_range(0, 7));
         a    = $urandom;
         b    = $urandom;
         pick = $urandom_range(0, 9);
         if (pick == 0) b = 32'd0;
         if (pick == 1) begin
            a = (sel == 0) ? 32'h8000_0000 : 32'h0000_8000;
            b = 32'hFFFF_FFFF;
         end
         if (pick == 2) b = 32'($urandom_range(1, 9));
         model_step(sel, op, a, b);
         run_op(sel, op, a, b, m_hi[sel], m_lo[sel], $sformatf("rand%0d op%0d", sel, op));
      end
   endtask

   initial begin
      vec_a[0] = '{3'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
      vec_a[1] = '{3'd1, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE};
      vec_a[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vec_a[3] = '{3'd3, 32'd7,         32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vec_a[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      vec_a[5] = '{3'd4, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'h8000_0000};
      vec_a[6] = '{3'd5, 32'hCAFE_F00D, 32'd0,         32'h1234_5678, 32'hCAFE_F00D};
      vec_a[7] = '{3'd6, 32'h1111_1111, 32'd3,         32'h1234_5678, 32'hCAFE_F00D};
      vec_a[8] = '{3'd7, 32'h2222_2222, 32'd5,         32'h1234_5678, 32'hCAFE_F00D};
      vec_b[0] = '{3'd0, 32'h0000_FFFD, 32'd7,         32'h0000_FFFF, 32'h0000_FFEB};
      vec_b[1] = '{3'd1, 32'h0000_FFFF, 32'd2,         32'h0000_0001, 32'h0000_FFFE};
      vec_b[2] = '{3'd2, 32'h0000_FFF9, 32'd2,         32'h0000_FFFF, 32'h0000_FFFD};

      drive(0, 1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
      drive(1, 1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
      m_hi = '{32'd0, 32'd0};
      m_lo = '{32'd0, 32'd0};
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int s = 0; s < 2; s++) begin
         check($sformatf("reset busy %0d", s), get_busy(s), 32'd0);
         check($sformatf("reset hi %0d", s), get_hi(s), 32'd0);
         check($sformatf("reset lo %0d", s), get_lo(s), 32'd0);
      end

      foreach (vec_a[i]) begin
         model_step(0, vec_a[i].op, vec_a[i].a, vec_a[i].b);
         run_op(0, vec_a[i].op, vec_a[i].a, vec_a[i].b, vec_a[i].hi, vec_a[i].lo,
                $sformatf("vec_a%0d", i));
      end

      // Cancel on busy cycle 4 of a DIV: busy drops at the next edge, HI/LO keep old values.
      @(negedge clk);
      drive(0, 1'b1, 3'd2, 32'd100, 32'd7, 1'b0);
      @(negedge clk);
      drive(0, 1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
      repeat (3) @(negedge clk);
      check("cancel busy c4", get_busy(0), 32'd1);
      drive(0, 1'b0, 3'd7, 32'd0, 32'd0, 1'b1);
      @(negedge clk);
      drive(0, 1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
      check("cancel busy drop", get_busy(0), 32'd0);
      repeat (12) @(negedge clk);
      check("cancel busy later", get_busy(0), 32'd0);
      check("cancel hi", get_hi(0), m_hi[0]);
      check("cancel lo", get_lo(0), m_lo[0]);

      // start together with cancel never raises busy.
      @(negedge clk);
      drive(0, 1'b1, 3'd0, 32'd3, 32'd4, 1'b1);
      @(negedge clk);
      drive(0, 1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
      check("start+cancel busy", get_busy(0), 32'd0);
      repeat (6) @(negedge clk);
      check("start+cancel busy later", get_busy(0), 32'd0);
      check("start+cancel hi", get_hi(0), m_hi[0]);
      check("start+cancel lo", get_lo(0), m_lo[0]);

      // Starts (MTHI, then DIV) while a MULT is in flight are ignored.
      @(negedge clk);
      drive(0, 1'b1, 3'd0, 32'd5, 32'd6, 1'b0);
      @(negedge clk);
      drive(0, 1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      drive(0, 1'b1, 3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0);
      @(negedge clk);
      drive(0, 1'b1, 3'd2, 32'd100, 32'd3, 1'b0);
      check("overlap hi held", get_hi(0), m_hi[0]);
      @(negedge clk);
      drive(0, 1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
      check("overlap busy c4", get_busy(0), 32'd1);
      @(negedge clk);
      check("overlap busy c5", get_busy(0), 32'd1);
      @(negedge clk);
      model_step(0, 3'd0, 32'd5, 32'd6);
      check("overlap busy done", get_busy(0), 32'd0);
      check("overlap hi", get_hi(0), m_hi[0]);
      check("overlap lo", get_lo(0), m_lo[0]);
      repeat (12) @(negedge clk);
      check("overlap busy stays low", get_busy(0), 32'd0);
      check("overlap lo later", get_lo(0), m_lo[0]);

      random_ops(0, 150);

      foreach (vec_b[i]) begin
         model_step(1, vec_b[i].op, vec_b[i].a, vec_b[i].b);
         run_op(1, vec_b[i].op, vec_b[i].a, vec_b[i].b, vec_b[i].hi, vec_b[i].lo,
                $sformatf("vec_b%0d", i));
      end
      random_ops(1, 80);

      // Reset on busy cycle 2 of a MULT discards the result and clears HI/LO.
      run_op(0, 3'd4, 32'hA5A5_0001, 32'd0, 32'hA5A5_0001, m_lo[0], "pre-reset mthi");
      m_hi[0] = 32'hA5A5_0001;
      @(negedge clk);
      drive(0, 1'b1, 3'd0, 32'd9, 32'd9, 1'b0);
      @(negedge clk);
      drive(0, 1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      check("reset-mid busy c2", get_busy(0), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_hi = '{32'd0, 32'd0};
      m_lo = '{32'd0, 32'd0};
      check("reset-mid busy", get_busy(0), 32'd0);
      check("reset-mid hi", get_hi(0), 32'd0);
      check("reset-mid lo", get_lo(0), 32'd0);
      repeat (6) @(negedge clk);
      check("reset-mid busy later", get_busy(0), 32'd0);
      check("reset-mid hi later", get_hi(0), 32'd0);
      check("reset-mid lo later", get_lo(0), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
